// File: rtl/lsu_unit.sv
// Load/store unit: one outstanding req/gnt/rvalid transaction on the data port.
// Ports: pipeline req_* in, mem_* bus, done_o/err_o one-cycle completion pulses.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t state_q, state_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] cnt_q;
  logic        err_q;
  logic [1:0]  cause_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        illegal;
  logic        misal;
  logic        tmo;
  logic [1:0]  sh;
  logic        sz_b;
  logic        sz_h;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] lane;
  logic [31:0] ext;

  assign accept  = req_valid_i && (state_q == IDLE);
  assign illegal = (req_size_i == 2'b11);
  assign misal   = ((req_size_i == 2'b01) && req_addr_i[0])
                || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));

  // Fires on the WAIT cycle that brings the count to TIMEOUT_CYCLES.
  assign tmo = (TIMEOUT_CYCLES != 0)
            && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);

  assign sh   = addr_q[1:0];
  assign sz_b = (size_q == 2'b00);
  assign sz_h = (size_q == 2'b01);
  assign lane = mem_rdata_i >> {sh, 3'b000};

  always_comb begin
    be  = 4'b1111;
    wd  = wdata_q;
    ext = lane;
    unique case (1'b1)
      sz_b: begin
        be  = 4'b0001 << sh;
        wd  = {4{wdata_q[7:0]}};
        ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
      end
      sz_h: begin
        be  = 4'b0011 << sh;
        wd  = {2{wdata_q[15:0]}};
        ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)
              state_d = (illegal || misal) ? RESP : REQ;
      REQ:  if (mem_gnt_i) state_d = WAIT;
      WAIT: if (mem_rvalid_i || tmo) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      cause_q <= 2'b00;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          we_q    <= req_we_i;
          size_q  <= req_size_i;
          uns_q   <= req_unsigned_i;
          addr_q  <= req_addr_i;
          wdata_q <= req_wdata_i;
          err_q   <= illegal || misal;
          cause_q <= illegal ? 2'b11 : (misal ? 2'b01 : 2'b00);
          rdata_q <= '0;
        end
        REQ: if (mem_gnt_i) cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 32'd1;
          // A response in the timeout cycle still completes normally.
          if (mem_rvalid_i) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'd0 : ext;
          end else if (tmo) begin
            err_q   <= 1'b1;
            cause_q <= 2'b10;
          end
        end
        RESP: begin
          err_q   <= 1'b0;
          cause_q <= 2'b00;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    load_data_o = '0;
    err_cause_o = 2'b00;
    if (state_q == REQ) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_q;
      mem_addr_o  = {addr_q[31:2], 2'b00};
      mem_be_o    = be;
      mem_wdata_o = wd;
    end
    if (state_q == RESP) begin
      done_o      = ~err_q;
      err_o       = err_q;
      load_data_o = rdata_q;
      err_cause_o = err_q ? cause_q : 2'b00;
    end
  end

endmodule
